// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle controller and the datapath muxes it drives.
// Holds the FSM state encoding, instruction classes, the mux-select encodings
// (reg_dst, reg_src, alu_src, pc_src, alu_op) and the supported opcode/funct values.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CLS_R_ALU,
        CLS_JR,
        CLS_I_ALU,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_NONE
    } instr_class_t;

    localparam logic [1:0] REG_DST_RT   = 2'b01;
    localparam logic [1:0] REG_DST_RD   = 2'b10;
    localparam logic [1:0] REG_DST_R31  = 2'b11;

    localparam logic [2:0] REG_SRC_ALU  = 3'b001;
    localparam logic [2:0] REG_SRC_MEM  = 3'b010;
    localparam logic [2:0] REG_SRC_IMM  = 3'b011;
    localparam logic [2:0] REG_SRC_LINK = 3'b100;

    localparam logic       ALU_SRC_REG  = 1'b0;
    localparam logic       ALU_SRC_IMM  = 1'b1;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_IALU  = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the controller and the instruction/data memories.
//   imem_req   ctrl -> mem  instruction read request
//   imem_ready mem  -> ctrl instruction word valid this cycle
//   dmem_re    ctrl -> mem  data read request
//   dmem_we    ctrl -> mem  data write request
//   dmem_ready mem  -> ctrl data access complete this cycle
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_re;
    logic dmem_we;
    logic dmem_ready;

    modport master (output imem_req, dmem_re, dmem_we, input imem_ready, dmem_ready);
    modport slave  (input imem_req, dmem_re, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// Combinational instruction classifier.
//   opcode  in  IR[31:26]
//   funct   in  IR[5:0], only used to split jr from the other R-type ops
//   cls     out instruction class
//   illegal out 1 when the opcode is not supported
module instr_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         illegal
);

    always_comb begin
        // NOTE: cls gets a default before the case so no path leaves it unassigned (no latch).
        cls = CLS_NONE;
        case (opcode)
            OP_RTYPE: cls = (funct == FUNCT_JR) ? CLS_JR : CLS_R_ALU;
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI: cls = CLS_I_ALU;
            OP_LUI:   cls = CLS_LUI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            default:  cls = CLS_NONE;
        endcase
        illegal = (cls == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of the CPU datapath
// with variable-latency memory handshakes and a per-access timeout.
//   clk, rst       clock, synchronous active-high reset
//   halt           1 = do not start a new fetch
//   opcode, funct  instruction fields, stable from DECODE onward
//   alu_zero       ALU zero flag, valid in EXEC
//   bus            memory handshake (master side)
//   ir_we, pc_we, pc_src, reg_we, reg_dst, alu_src, alu_op, reg_src  datapath controls
//   state_o        current state for debug
//   illegal        1-cycle pulse on unsupported instruction
//   bus_err        1-cycle pulse on memory timeout
// Controls are combinational from the state, the latched class, alu_zero and the
// ready inputs, so a memory response is consumed in the cycle it arrives.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    multicycle_ctrl_if.master bus,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [2:0] reg_src,
    output logic [2:0] state_o,
    output logic       illegal,
    output logic       bus_err
);

    state_t          state;
    instr_class_t    cls_q;
    logic [TO_W-1:0] to_cnt;
    logic            fetch_pending;   // a fetch was raised and must finish even if halt rises

    instr_class_t    dec_cls;
    logic            dec_illegal;

    instr_class_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    logic fetch_req, fetch_done, mem_done, waiting, timeout;
    logic imem_req_c, dmem_re_c, dmem_we_c;

    assign fetch_req  = (state == ST_FETCH) && (!halt || fetch_pending);
    assign fetch_done = fetch_req && bus.imem_ready;
    assign mem_done   = (state == ST_MEM) && bus.dmem_ready;
    assign waiting    = (fetch_req && !bus.imem_ready) ||
                        ((state == ST_MEM) && !bus.dmem_ready);
    // Ready has priority: timeout only fires while still waiting.
    assign timeout    = waiting && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FETCH;
            cls_q         <= CLS_NONE;
            to_cnt        <= '0;
            fetch_pending <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every branch reads pre-edge values.
            case (state)
                ST_FETCH: begin
                    if (fetch_done) begin
                        state         <= ST_DECODE;
                        fetch_pending <= 1'b0;
                        to_cnt        <= '0;
                    end else if (timeout) begin
                        // Abort without pc_we: the same PC is fetched again.
                        fetch_pending <= 1'b0;
                        to_cnt        <= '0;
                    end else if (fetch_req) begin
                        fetch_pending <= 1'b1;
                        to_cnt        <= to_cnt + 1'b1;
                    end else begin
                        to_cnt <= '0;
                    end
                end
                ST_DECODE: begin
                    cls_q  <= dec_cls;
                    to_cnt <= '0;
                    state  <= dec_illegal ? ST_FETCH : ST_EXEC;
                end
                ST_EXEC: begin
                    to_cnt <= '0;
                    case (cls_q)
                        CLS_R_ALU, CLS_I_ALU, CLS_LUI: state <= ST_WB;
                        CLS_LW, CLS_SW:                state <= ST_MEM;
                        default:                       state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (mem_done) begin
                        state  <= (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
                        to_cnt <= '0;
                    end else if (timeout) begin
                        state  <= ST_FETCH;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_FETCH;
                    to_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        imem_req_c = 1'b0;
        dmem_re_c  = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_PC4;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        alu_src    = ALU_SRC_REG;
        alu_op     = ALU_OP_ADD;
        reg_src    = REG_SRC_ALU;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        // While rst is high every strobe and request is held low.
        if (!rst) begin
            bus_err = timeout;
            case (state)
                ST_FETCH: begin
                    imem_req_c = fetch_req;
                    ir_we      = fetch_done;
                    pc_we      = fetch_done;
                end
                ST_DECODE: illegal = dec_illegal;
                ST_EXEC: begin
                    case (cls_q)
                        CLS_R_ALU: alu_op = ALU_OP_FUNCT;
                        CLS_JR: begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_RS;
                        end
                        CLS_I_ALU: begin
                            alu_src = ALU_SRC_IMM;
                            alu_op  = ALU_OP_IALU;
                        end
                        CLS_LW, CLS_SW: alu_src = ALU_SRC_IMM;
                        CLS_BEQ, CLS_BNE: begin
                            alu_op = ALU_OP_SUB;
                            pc_we  = (cls_q == CLS_BEQ) ? alu_zero : !alu_zero;
                            pc_src = pc_we ? PC_SRC_BRANCH : PC_SRC_PC4;
                        end
                        CLS_J: begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_JUMP;
                        end
                        CLS_JAL: begin
                            pc_we   = 1'b1;
                            pc_src  = PC_SRC_JUMP;
                            reg_we  = 1'b1;
                            reg_dst = REG_DST_R31;
                            reg_src = REG_SRC_LINK;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    dmem_re_c = (cls_q == CLS_LW);
                    dmem_we_c = (cls_q == CLS_SW);
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    case (cls_q)
                        CLS_R_ALU: reg_dst = REG_DST_RD;
                        CLS_LUI:   reg_src = REG_SRC_IMM;
                        CLS_LW:    reg_src = REG_SRC_MEM;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_re  = dmem_re_c;
    assign bus.dmem_we  = dmem_we_c;
    assign state_o      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A transaction-level model expands each
// instruction (with its chosen memory wait counts) into the per-cycle control
// vector the controller must produce; the bench replays the stimulus and compares.
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 16;

    // Instruction kinds, bench-local.
    localparam int K_R = 0, K_JR = 1, K_I = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

    logic       clk = 1'b0;
    logic       rst, halt, alu_zero;
    logic [5:0] opcode, funct;
    logic       ir_we, pc_we, reg_we, alu_src, illegal, bus_err;
    logic [1:0] pc_src, reg_dst, alu_op;
    logic [2:0] reg_src, state_o;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .opcode   (opcode),
        .funct    (funct),
        .alu_zero (alu_zero),
        .bus      (bus),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .reg_we   (reg_we),
        .reg_dst  (reg_dst),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .reg_src  (reg_src),
        .state_o  (state_o),
        .illegal  (illegal),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       dmem_re;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] reg_src;
        logic       illegal;
        logic       bus_err;
    } obs_t;

    typedef struct {
        logic       halt;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       alu_zero;
        logic       imem_ready;
        logic       dmem_ready;
    } stim_t;

    stim_t sq[$];
    obs_t  eq[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic obs_t idle(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.state   = st;
        o.reg_dst = 2'b01;
        o.reg_src = 3'b001;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.state    = state_o;
        o.imem_req = bus.imem_req;
        o.dmem_re  = bus.dmem_re;
        o.dmem_we  = bus.dmem_we;
        o.ir_we    = ir_we;
        o.pc_we    = pc_we;
        o.pc_src   = pc_src;
        o.reg_we   = reg_we;
        o.reg_dst  = reg_dst;
        o.alu_src  = alu_src;
        o.alu_op   = alu_op;
        o.reg_src  = reg_src;
        o.illegal  = illegal;
        o.bus_err  = bus_err;
        return o;
    endfunction

    // Irrelevant inputs are randomised so the controller must ignore them.
    function automatic stim_t fresh(input logic [5:0] op, input logic [5:0] fn, input logic zero);
        stim_t s;
        s.halt       = 1'($urandom_range(0, 1));
        s.opcode     = op;
        s.funct      = fn;
        s.alu_zero   = zero;
        s.imem_ready = 1'($urandom_range(0, 1));
        s.dmem_ready = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                             return (fn == 6'h08) ? K_JR : K_R;
            6'h02:                             return K_J;
            6'h03:                             return K_JAL;
            6'h04:                             return K_BEQ;
            6'h05:                             return K_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: return K_I;
            6'h0F:                             return K_LUI;
            6'h23:                             return K_LW;
            6'h2B:                             return K_SW;
            default:                           return K_ILL;
        endcase
    endfunction

    task automatic push(input stim_t s, input obs_t o);
        sq.push_back(s);
        eq.push_back(o);
    endtask

    // Expand one instruction into expected cycles. fwait/mwait are the number of
    // non-ready request cycles before ready; every MEM_TIMEOUT-th consecutive
    // non-ready cycle is a bus error.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input int halt_idle, input int fwait, input int mwait,
                               input bit halt_in_wait);
        stim_t s;
        obs_t  o;
        int    k;
        int    cnt;
        k = kind_of(op, fn);
        for (int i = 0; i < halt_idle; i++) begin
            s        = fresh(6'($urandom), 6'($urandom), zero);
            s.halt   = 1'b1;
            push(s, idle(3'd0));
        end
        cnt = 0;
        for (int w = 0; w < fwait; w++) begin
            s            = fresh(op, fn, zero);
            s.halt       = halt_in_wait && (w > 0);
            s.imem_ready = 1'b0;
            o            = idle(3'd0);
            o.imem_req   = 1'b1;
            cnt++;
            if (cnt == MEM_TIMEOUT) begin
                o.bus_err = 1'b1;
                cnt       = 0;
            end
            push(s, o);
        end
        s            = fresh(op, fn, zero);
        s.halt       = halt_in_wait && (fwait > 0);
        s.imem_ready = 1'b1;
        o            = idle(3'd0);
        o.imem_req   = 1'b1;
        o.ir_we      = 1'b1;
        o.pc_we      = 1'b1;
        push(s, o);
        s = fresh(op, fn, zero);
        o = idle(3'd1);
        o.illegal = (k == K_ILL);
        push(s, o);
        if (k == K_ILL) return;
        s = fresh(op, fn, zero);
        o = idle(3'd2);
        case (k)
            K_R:   o.alu_op = 2'b10;
            K_JR:  begin o.pc_we = 1'b1; o.pc_src = 2'b11; end
            K_I:   begin o.alu_src = 1'b1; o.alu_op = 2'b11; end
            K_LW, K_SW: o.alu_src = 1'b1;
            K_BEQ, K_BNE: begin
                o.alu_op = 2'b01;
                if ((k == K_BEQ && zero) || (k == K_BNE && !zero)) begin
                    o.pc_we  = 1'b1;
                    o.pc_src = 2'b01;
                end
            end
            K_J:   begin o.pc_we = 1'b1; o.pc_src = 2'b10; end
            K_JAL: begin
                o.pc_we = 1'b1; o.pc_src = 2'b10;
                o.reg_we = 1'b1; o.reg_dst = 2'b11; o.reg_src = 3'b100;
            end
            default: ;
        endcase
        push(s, o);
        if (k == K_JR || k == K_BEQ || k == K_BNE || k == K_J || k == K_JAL) return;
        if (k == K_LW || k == K_SW) begin
            cnt = 0;
            for (int w = 0; w < mwait; w++) begin
                s            = fresh(op, fn, zero);
                s.dmem_ready = 1'b0;
                o            = idle(3'd3);
                o.dmem_re    = (k == K_LW);
                o.dmem_we    = (k == K_SW);
                cnt++;
                if (cnt == MEM_TIMEOUT) begin
                    o.bus_err = 1'b1;
                    push(s, o);
                    return;
                end
                push(s, o);
            end
            s            = fresh(op, fn, zero);
            s.dmem_ready = 1'b1;
            o            = idle(3'd3);
            o.dmem_re    = (k == K_LW);
            o.dmem_we    = (k == K_SW);
            push(s, o);
            if (k == K_SW) return;
        end
        s        = fresh(op, fn, zero);
        o        = idle(3'd4);
        o.reg_we = 1'b1;
        if (k == K_R)   o.reg_dst = 2'b10;
        if (k == K_LUI) o.reg_src = 3'b011;
        if (k == K_LW)  o.reg_src = 3'b010;
        push(s, o);
    endtask

    task automatic apply(input stim_t s);
        halt           = s.halt;
        opcode         = s.opcode;
        funct          = s.funct;
        alu_zero       = s.alu_zero;
        bus.imem_ready = s.imem_ready;
        bus.dmem_ready = s.dmem_ready;
    endtask

    // Replays up to max_n queued cycles; entered and left just after a rising edge.
    task automatic run(input string name, input int max_n);
        obs_t got;
        int   n;
        n = (max_n < sq.size()) ? max_n : sq.size();
        for (int i = 0; i < n; i++) begin
            apply(sq[i]);
            @(negedge clk);
            got = sample();
            n_vec++;
            if (got !== eq[i]) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h (state %0d) want %h (state %0d)",
                         name, i, got, got.state, eq[i], eq[i].state);
            end
            @(posedge clk);
            #1;
        end
        sq.delete();
        eq.delete();
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; halt = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        got = sample();
        n_vec++;
        if (got !== idle(3'd0)) begin
            n_err++;
            $display("FAIL reset_init: got %h want %h", got, idle(3'd0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Park an sw in MEM with dmem_we pending, then reset for two cycles.
        model_instr(6'h2B, 6'h00, 1'b0, 0, 0, 20, 1'b0);
        run("reset_pre", 5);
        rst = 1'b1;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        got = sample();
        n_vec++;
        if ({got.state, got.ir_we, got.pc_we, got.reg_we} !== {3'd3, 3'b000}) begin
            n_err++;
            $display("FAIL reset_mid_c0: got state %0d we %b%b%b want state 3 we 000",
                     got.state, got.ir_we, got.pc_we, got.reg_we);
        end
        @(posedge clk); #1;
        @(negedge clk);
        got = sample();
        n_vec++;
        if (got !== idle(3'd0)) begin
            n_err++;
            $display("FAIL reset_mid_c1: got %h want %h", got, idle(3'd0));
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = sample();
            n_vec++;
            if (got !== idle(3'd0)) begin
                n_err++;
                $display("FAIL reset_release %0d: got %h want %h", i, got, idle(3'd0));
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
    endtask

    task automatic test_add();
        model_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h02, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        run("add", 1000);
    endtask

    task automatic test_lw_delayed();
        model_instr(6'h23, 6'h00, 1'b1, 0, 0, 3, 1'b0);
        model_instr(6'h2B, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        run("lw_delayed", 1000);
    endtask

    task automatic test_branches();
        model_instr(6'h04, 6'h11, 1'b1, 0, 0, 0, 1'b0);
        model_instr(6'h04, 6'h11, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h05, 6'h22, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h05, 6'h22, 1'b1, 0, 0, 0, 1'b0);
        model_instr(6'h03, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h02, 6'h00, 1'b1, 0, 0, 0, 1'b0);
        model_instr(6'h00, 6'h08, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h0F, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        run("branch_jump", 1000);
    endtask

    task automatic test_fetch_timeout();
        model_instr(6'h02, 6'h00, 1'b0, 0, 16, 0, 1'b0);
        model_instr(6'h02, 6'h00, 1'b0, 0, 15, 0, 1'b0);
        model_instr(6'h0D, 6'h00, 1'b0, 0, 35, 0, 1'b0);
        run("fetch_timeout", 1000);
    endtask

    task automatic test_mem_timeout();
        model_instr(6'h23, 6'h00, 1'b0, 0, 0, 16, 1'b0);
        model_instr(6'h2B, 6'h00, 1'b0, 0, 0, 15, 1'b0);
        model_instr(6'h2B, 6'h00, 1'b0, 0, 0, 16, 1'b0);
        model_instr(6'h23, 6'h00, 1'b0, 0, 0, 15, 1'b0);
        run("mem_timeout", 1000);
    endtask

    task automatic test_illegal();
        model_instr(6'h3F, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h0B, 6'h00, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h01, 6'h08, 1'b0, 0, 0, 0, 1'b0);
        model_instr(6'h20, 6'h00, 1'b0, 0, 2, 0, 1'b0);
        run("illegal", 1000);
    endtask

    task automatic test_halt();
        model_instr(6'h02, 6'h00, 1'b0, 40, 0, 0, 1'b0);
        model_instr(6'h00, 6'h25, 1'b0, 0, 4, 0, 1'b1);
        model_instr(6'h23, 6'h00, 1'b0, 3, 1, 1, 1'b1);
        run("halt", 1000);
    endtask

    task automatic test_back_to_back_random();
        logic [5:0] ops [16];
        logic [5:0] op, fn;
        int         fw, mw;
        bit         hw;
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A,
                6'h0E, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h2B, 6'h3F, 6'h0B};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 15)];
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 2) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? 15 + $urandom_range(0, 2) : $urandom_range(0, 4);
            hw = (fw < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            model_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), fw, mw, hw);
        end
        run("random", 100000);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_delayed();
        test_branches();
        test_fetch_timeout();
        test_mem_timeout();
        test_illegal();
        test_halt();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the existing CPU datapath: register file, ALU, PC and the instruction and data memories. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with both memories. Each cycle it drives the reg_dst, alu_src and reg_src mux selects plus all write strobes. It replaces the single-cycle combinational decoder when memories have variable latency.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for imem_ready/dmem_ready before abort (≥2)
TO_W, 5, timeout counter width (≥ clog2(MEM_TIMEOUT)+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
halt  in  1  1 = do not start a new fetch
opcode  in  6  IR[31:26], stable from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag, valid in EXEC
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access complete this cycle
imem_req  out  1  instruction read request
dmem_re  out  1  data read request
dmem_we  out  1  data write request
ir_we  out  1  latch IR and link value (PC+4)
pc_we  out  1  PC write enable
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
reg_we  out  1  register file write enable
reg_dst  out  2  01 rt, 10 rd, 11 r31 (00 unused)
alu_src  out  1  0 register, 1 immediate
alu_op  out  2  00 ADD, 01 SUB, 10 by funct, 11 by opcode (I-ALU)
reg_src  out  3  001 ALU, 010 MEM, 011 ext-imm, 100 link (PC+4)
state_o  out  3  current state, for debug
illegal  out  1  1-cycle pulse on unsupported opcode/funct
bus_err  out  1  1-cycle pulse on memory timeout

Behaviour:
- Reset:
  - state=FETCH, timeout counter=0.
  - All strobes 0, reg_dst=01, reg_src=001, alu_src=0, alu_op=00, pc_src=00.
  - Reset mid-access drops the request next cycle; no pc_we or reg_we is issued.
- Outputs are combinational from state, latched opcode/funct class, alu_zero and the ready inputs.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH:
  - imem_req = !halt.
  - On imem_ready: ir_we=1, pc_we=1, pc_src=00; go to DECODE.
- DECODE:
  - Latch instruction class.
  - Unsupported instruction: illegal=1, go to FETCH.
  - Otherwise go to EXEC.
- EXEC, by class:
  - R-ALU (op 0, funct≠08): alu_src=0, alu_op=10, go to WB.
  - jr (op 0, funct 08): pc_we=1, pc_src=11, go to FETCH.
  - I-ALU (addi/addiu/slti/andi/ori/xori): alu_src=1, alu_op=11, go to WB.
  - lui: go to WB.
  - lw/sw: alu_src=1, alu_op=00, go to MEM.
  - beq/bne: alu_src=0, alu_op=01. pc_we=1, pc_src=01 iff (beq && alu_zero) || (bne && !alu_zero). Go to FETCH.
  - j: pc_we=1, pc_src=10, go to FETCH.
  - jal: pc_we=1, pc_src=10, reg_we=1, reg_dst=11, reg_src=100, go to FETCH.
- MEM:
  - dmem_re (lw) or dmem_we (sw) is held until dmem_ready.
  - On ready: lw goes to WB, sw goes to FETCH.
- WB: reg_we=1 for exactly one cycle, then go to FETCH.
  - R-ALU: reg_dst=10, reg_src=001.
  - I-ALU: reg_dst=01, reg_src=001.
  - lui: reg_dst=01, reg_src=011.
  - lw: reg_dst=01, reg_src=010.
- Latency with zero-wait memory (ready on first request cycle):
  - R/I/lui: 4 cycles. lw: 5. sw: 4.
  - Branch/jump/jr/jal: 3. Illegal: 2.
- Timeout counter:
  - Cleared on entering FETCH/MEM and whenever halt=1.
  - Increments each waiting cycle without ready.
  - When it reaches MEM_TIMEOUT-1 without ready: bus_err=1 and go to FETCH.
  - A FETCH timeout does no pc_we, so the same PC is re-fetched. A MEM timeout does no reg_we.
  - Ready and timeout in the same cycle: ready wins, no bus_err.
- halt is sampled only in FETCH before a request is raised. A fetch already requested (imem_req=1, no ready yet) completes regardless of halt.
- At most one of dmem_re/dmem_we is ever 1. pc_we and reg_we are never 1 outside the states listed.

Decomposition:
- Shared constants header (same include as the datapath muxes) holds:
  - REG_DST_*, REG_SRC_*, ALU_SRC_* encodings.
  - New PC_SRC_*, ALU_OP_* and STATE_* defines.
  - Opcode/funct defines.
- One sub-module, instr_class_decode: combinational opcode/funct → class + illegal flag, instantiated once.
- FSM, timeout counter and output logic stay in multicycle_ctrl.

Test Plan:
- rst=1 for 2 cycles during a pending dmem_we → state_o=0, all strobes 0, no pc_we/reg_we after release.
- add (op 0, funct 0x20), ready always 1 → ir_we@c0, EXEC alu_op=10, WB reg_we=1 with reg_dst=10 and reg_src=001 @c3, imem_req again @c4.
- lw with dmem_ready delayed 3 cycles → dmem_re held 4 cycles, then WB reg_src=010, reg_dst=01, total 8 cycles.
- beq with alu_zero=1 → pc_we=1, pc_src=01 in EXEC. Repeat with alu_zero=0 → pc_we=0. jal → reg_dst=11, reg_src=100, pc_src=10 in the same cycle.
- imem_ready never asserted, MEM_TIMEOUT=16 → bus_err pulse after 16 request cycles, no pc_we, re-fetch; imem_ready on the timeout cycle → no bus_err.
- opcode 0x3F → illegal pulse in DECODE, back to FETCH after 2 cycles. halt=1 in FETCH → imem_req stays 0 indefinitely, no bus_err.
